// File: rtl/sd_sector_streamer_if.sv
// rtl/sd_sector_streamer_if.sv - control, SD controller read side and byte-stream signals of the sector streamer
interface sd_sector_streamer_if #(
    parameter int FIFO_DEPTH = 1024
) ();
    logic                        start;
    logic [22:0]                 start_sector;
    logic [15:0]                 num_sectors;
    logic                        busy;
    logic                        done;
    logic                        overflow;
    logic                        sd_ready;
    logic                        sd_rd;
    logic [31:0]                 sd_address;
    logic [7:0]                  sd_dout;
    logic                        sd_byte_available;
    logic [7:0]                  out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        input  start, start_sector, num_sectors, sd_ready, sd_dout, sd_byte_available, out_ready,
        output busy, done, overflow, sd_rd, sd_address, out_data, out_valid, fifo_count
    );

    modport slave (
        output start, start_sector, num_sectors, sd_ready, sd_dout, sd_byte_available, out_ready,
        input  busy, done, overflow, sd_rd, sd_address, out_data, out_valid, fifo_count
    );
endinterface

// File: rtl/sd_sector_streamer.sv
// rtl/sd_sector_streamer.sv - issues back-to-back SD block reads and streams the bytes through a FWFT FIFO
module sd_sector_streamer #(
    parameter int FIFO_DEPTH  = 1024,
    parameter int BLOCK_BYTES = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    sd_sector_streamer_if.master bus
);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam int             CW        = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  BLOCK_C   = CW'(BLOCK_BYTES);
    localparam logic [9:0]     LAST_BYTE = 10'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_ISSUE,
        S_RECEIVE,
        S_WAIT_READY
    } state_t;

    state_t        state_q, state_d;
    logic [22:0]   cur_sector_q, cur_sector_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [9:0]    byte_cnt_q, byte_cnt_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic push_req;
    logic push_en;
    logic pop;
    logic full;

    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
    assign full     = (count_q == DEPTH_C);
    assign pop      = (count_q != '0) && bus.out_ready;
    assign push_req = (state_q == S_RECEIVE) && bus.sd_byte_available;
    assign push_en  = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_req && !push_en) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_sector_d = cur_sector_q;
        remaining_d  = remaining_q;
        byte_cnt_d   = byte_cnt_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cur_sector_d = bus.start_sector;
                    remaining_d  = bus.num_sectors;
                    if (bus.num_sectors == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_SPACE;
                    end
                end
            end
            S_WAIT_SPACE: begin
                if (((DEPTH_C - count_q) >= BLOCK_C) && bus.sd_ready) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                byte_cnt_d = '0;
                state_d    = S_RECEIVE;
            end
            S_RECEIVE: begin
                // Dropped bytes still count so the sector boundary stays aligned with the card.
                if (push_req) begin
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        cur_sector_d = cur_sector_q + 23'd1;
                        remaining_d  = remaining_q - 16'd1;
                        state_d      = S_WAIT_READY;
                    end
                end
            end
            S_WAIT_READY: begin
                if (bus.sd_ready) begin
                    if (remaining_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_SPACE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_sector_q <= '0;
            remaining_q  <= '0;
            byte_cnt_q   <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_sector_q <= cur_sector_d;
            remaining_q  <= remaining_d;
            byte_cnt_q   <= byte_cnt_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= bus.sd_dout;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.sd_rd      = (state_q == S_ISSUE);
    assign bus.sd_address = {cur_sector_q, 9'b0};
    assign bus.out_data   = mem_q[rd_ptr_q];
    assign bus.out_valid  = (count_q != '0);
    assign bus.fifo_count = count_q;
endmodule

// File: doc/sd_sector_streamer.md
Name: sd_sector_streamer

Overview:
- Sits directly downstream of the SD card SPI controller, on its read side.
- Given a start sector and a sector count, it issues back-to-back 512-byte block reads to the controller.
- Captures every byte the controller presents into an internal first-word-fall-through FIFO and streams the bytes to a valid/ready consumer (bitstream parser / decoder front end).
- The controller cannot be stalled mid-block, so a read is issued only when the FIFO has room for a whole sector.

Parameters:
- FIFO_DEPTH, 1024, FIFO entries in bytes; must be a power of two and at least 512.
- BLOCK_BYTES, 512, bytes per SD sector; fixed by the card, not to be overridden.

Ports:
- clk  in  1  25 MHz system clock, same clock as the SD controller.
- reset  in  1  synchronous, active-high; clears all state and flushes the FIFO.
- start  in  1  one-cycle pulse; accepted only while busy=0.
- start_sector  in  23  first sector index; sampled on an accepted start.
- num_sectors  in  16  number of sectors to read; sampled on an accepted start.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse once the last byte of the last sector has been pushed into the FIFO.
- overflow  out  1  sticky error flag; set if a byte arrives while the FIFO is full; cleared only by reset.
- sd_ready  in  1  controller idle and able to accept a command.
- sd_rd  out  1  read request to the controller.
- sd_address  out  32  byte address of the block = {sector, 9'b0}.
- sd_dout  in  8  byte from the controller.
- sd_byte_available  in  1  one-cycle strobe marking sd_dout valid.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: busy=0, done=0, overflow=0, sd_rd=0, sd_address=0, out_valid=0, fifo_count=0; FSM in S_IDLE.
- Reset mid-transfer abandons the sector in progress. Integration resets the controller on the same reset net.
- FSM states and transitions:
  - S_IDLE:
    - start=1 latches cur_sector=start_sector and remaining=num_sectors.
    - If num_sectors==0: done pulses next cycle, busy stays 0, no read issued.
    - Otherwise go to S_WAIT_SPACE and set busy=1.
  - S_WAIT_SPACE: go to S_ISSUE when (FIFO_DEPTH - fifo_count) >= 512 and sd_ready=1.
  - S_ISSUE:
    - Drive sd_rd=1 for exactly one cycle, with sd_address={cur_sector,9'b0} stable from this cycle until leaving S_RECEIVE.
    - Clear byte_cnt to 0 and go to S_RECEIVE.
  - S_RECEIVE:
    - Each sd_byte_available=1 pushes sd_dout and increments byte_cnt (10 bits).
    - On the 512th push: cur_sector <= cur_sector+1 (wraps modulo 2^23), remaining <= remaining-1, go to S_WAIT_READY.
  - S_WAIT_READY (the controller is still clocking in the CRC):
    - Wait for sd_ready=1.
    - If remaining==0: go to S_IDLE, done=1 for that one cycle, busy=0.
    - Otherwise go to S_WAIT_SPACE.
- sd_byte_available outside S_RECEIVE is ignored; it is not pushed.
- Start while busy=1 is ignored.
- FIFO:
  - Push = S_RECEIVE && sd_byte_available. Pop = out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_count unchanged, and both occur.
  - Push while full with no pop: the byte is dropped, overflow is set, and byte_cnt still increments so sector framing is kept.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - out_data is valid in the same cycle out_valid is high (FWFT). A pushed byte is visible at the head 1 cycle after the push.
- Byte order out equals card order: sector N bytes 0..511, then sector N+1.
- Latency: sd_rd rises ≥1 cycle after the cycle in which start is accepted, with an empty FIFO and sd_ready=1.
- The space check makes overflow impossible with a conforming controller. It exists for verification only.

Test Plan:
- Single sector: reset, start with start_sector=5 and num_sectors=1; controller model sends 0x00..0xFF twice. Required: exactly one sd_rd pulse with sd_address=0x00000A00, 512 bytes out in order with out_ready=1, one done pulse, overflow=0.
- Multi-sector with backpressure: num_sectors=3, FIFO_DEPTH=1024, out_ready held 0. Required: two reads issue (addresses 0x0000, 0x0200), the third waits until fifo_count ≤512. Raise out_ready: third read at 0x0400, 1536 bytes out in order, overflow=0.
- Zero count: start with num_sectors=0. Required: done pulses one cycle later, sd_rd never asserts, busy stays 0.
- Sector wrap: start_sector=0x7FFFFF, num_sectors=2. Required: sd_address=0xFFFFFE00, then 0x00000000.
- Simultaneous push/pop: with fifo_count=10, assert byte_available and out_ready in the same cycle. Required: fifo_count stays 10 and data order is preserved. A forced full FIFO plus an extra byte sets overflow=1, and it stays 1 until reset.
- Reset mid-sector: assert reset after 100 bytes of sector 0. Required: all outputs return to reset values next cycle and fifo_count=0. A new start then reads from the new start_sector.
